// File: rtl/multicycle_control_unit_pkg.sv
// Shared opcode, state and datapath-select encodings for the multi-cycle control unit.
package multicycle_control_unit_pkg;

    localparam logic [3:0] OpBne = 4'd0;
    localparam logic [3:0] OpBeq = 4'd1;
    localparam logic [3:0] OpAdi = 4'd4;
    localparam logic [3:0] OpOri = 4'd5;
    localparam logic [3:0] OpLhi = 4'd6;
    localparam logic [3:0] OpLwd = 4'd7;
    localparam logic [3:0] OpSwd = 4'd8;
    localparam logic [3:0] OpJmp = 4'd9;
    localparam logic [3:0] OpJal = 4'd10;
    localparam logic [3:0] OpHlt = 4'd11;
    localparam logic [3:0] OpAlu = 4'd15;

    localparam logic [2:0] StIf   = 3'd0;
    localparam logic [2:0] StId   = 3'd1;
    localparam logic [2:0] StEx   = 3'd2;
    localparam logic [2:0] StMem  = 3'd3;
    localparam logic [2:0] StWb   = 3'd4;
    localparam logic [2:0] StHalt = 3'd5;
    localparam logic [2:0] StErr  = 3'd6;

    localparam logic [1:0] PcSrcNext   = 2'b00;
    localparam logic [1:0] PcSrcJump   = 2'b01;
    localparam logic [1:0] PcSrcBranch = 2'b10;

    localparam logic [1:0] AluSrcReg  = 2'b00;
    localparam logic [1:0] AluSrcSext = 2'b01;
    localparam logic [1:0] AluSrcZext = 2'b10;

    localparam logic [1:0] WbSrcAlu = 2'b00;
    localparam logic [1:0] WbSrcMem = 2'b01;
    localparam logic [1:0] WbSrcPc  = 2'b10;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluLhi = 3'b110;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] alu_src;
        logic [2:0] alu_ctrl;
        logic [1:0] wb_src;
        logic       lhi;
        logic       inst_done;
        logic       mem_timeout;
        logic       halted;
    } mcu_ctrl_t;

    // Opcodes that continue past ID into an execute cycle.
    function automatic logic needs_ex(logic [3:0] op);
        unique case (op)
            OpAlu, OpAdi, OpOri, OpLhi, OpLwd, OpSwd, OpBne, OpBeq, OpJal: needs_ex = 1'b1;
            default:                                                      needs_ex = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_unit_wait_counter.sv
// Memory-wait counter: counts consecutive stalled cycles, clears otherwise, saturates.
module multicycle_control_unit_wait_counter #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic inc_i,
    output logic expired_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = 8'd0;
        if (inc_i) begin
            cnt_d = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // True on the stalled cycle that would be the MEM_TIMEOUT-th consecutive wait.
    assign expired_o = 32'(cnt_q) >= (MEM_TIMEOUT - 32'd1);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: IF/ID/EX/MEM/WB sequencing with memory handshake and timeout.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int unsigned WORD_SIZE   = 16,
    parameter int unsigned ALU_CTRL_W  = 3,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic [WORD_SIZE-1:0]  inst_i,
    input  logic                  alu_zero_i,
    input  logic                  mem_ready_i,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic                  i_or_d_o,
    output logic                  ir_write_o,
    output logic                  pc_write_o,
    output logic [1:0]            pc_src_o,
    output logic                  reg_write_o,
    output logic                  reg_dst_o,
    output logic [1:0]            alu_src_o,
    output logic [ALU_CTRL_W-1:0] alu_control_o,
    output logic [1:0]            wb_src_o,
    output logic                  lhi_o,
    output logic                  inst_done_o,
    output logic                  mem_timeout_o,
    output logic                  halted_o
);

    logic [2:0] state_q, state_d;
    logic       run_q;
    logic [3:0] opcode;
    logic       stall, expired;
    mcu_ctrl_t  ctrl;
    logic       unused_inst;

    assign opcode      = inst_i[WORD_SIZE-1 -: 4];
    assign unused_inst = ^inst_i[WORD_SIZE-5:3];
    assign stall       = run_q && !mem_ready_i && (state_q == StIf || state_q == StMem);

    multicycle_control_unit_wait_counter #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_counter (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .inc_i     (stall),
        .expired_o (expired)
    );

    always_comb begin
        state_d = state_q;
        if (run_q) begin
            unique case (state_q)
                StIf: begin
                    if (mem_ready_i)  state_d = StId;
                    else if (expired) state_d = StErr;
                end
                StId: begin
                    if (opcode == OpHlt)       state_d = StHalt;
                    else if (needs_ex(opcode)) state_d = StEx;
                    else                       state_d = StIf;
                end
                StEx: begin
                    unique case (opcode)
                        OpLwd, OpSwd:               state_d = StMem;
                        OpAlu, OpAdi, OpOri, OpLhi: state_d = StWb;
                        default:                    state_d = StIf;
                    endcase
                end
                StMem: begin
                    if (mem_ready_i)  state_d = (opcode == OpLwd) ? StWb : StIf;
                    else if (expired) state_d = StErr;
                end
                StWb:    state_d = StIf;
                StHalt:  state_d = StHalt;
                default: state_d = StErr;
            endcase
        end
    end

    // run_q keeps every output low until the first edge after reset release.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StIf;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        ctrl = '0;
        if (run_q) begin
            unique case (state_q)
                StIf: begin
                    ctrl.mem_read = 1'b1;
                    if (mem_ready_i) begin
                        ctrl.ir_write = 1'b1;
                        ctrl.pc_write = 1'b1;
                        ctrl.pc_src   = PcSrcNext;
                    end
                end
                StId: begin
                    if (opcode == OpJmp) begin
                        ctrl.pc_write  = 1'b1;
                        ctrl.pc_src    = PcSrcJump;
                        ctrl.inst_done = 1'b1;
                    end else if (opcode == OpHlt) begin
                        ctrl.halted    = 1'b1;
                        ctrl.inst_done = 1'b1;
                    end else if (!needs_ex(opcode)) begin
                        ctrl.inst_done = 1'b1;
                    end
                end
                StEx: begin
                    unique case (opcode)
                        OpAlu: begin
                            ctrl.alu_ctrl = inst_i[2:0];
                            ctrl.alu_src  = AluSrcReg;
                        end
                        OpAdi, OpLwd, OpSwd: begin
                            ctrl.alu_ctrl = AluAdd;
                            ctrl.alu_src  = AluSrcSext;
                        end
                        OpOri: begin
                            ctrl.alu_ctrl = AluOr;
                            ctrl.alu_src  = AluSrcZext;
                        end
                        OpLhi: begin
                            ctrl.alu_ctrl = AluLhi;
                            ctrl.alu_src  = AluSrcZext;
                        end
                        OpBne, OpBeq: begin
                            ctrl.alu_ctrl  = AluSub;
                            ctrl.inst_done = 1'b1;
                            if ((opcode == OpBeq) == alu_zero_i) begin
                                ctrl.pc_write = 1'b1;
                                ctrl.pc_src   = PcSrcBranch;
                            end
                        end
                        OpJal: begin
                            ctrl.reg_write = 1'b1;
                            ctrl.wb_src    = WbSrcPc;
                            ctrl.pc_write  = 1'b1;
                            ctrl.pc_src    = PcSrcJump;
                            ctrl.inst_done = 1'b1;
                        end
                        default: ;
                    endcase
                end
                StMem: begin
                    ctrl.i_or_d    = 1'b1;
                    ctrl.mem_read  = (opcode == OpLwd);
                    ctrl.mem_write = (opcode == OpSwd);
                    ctrl.inst_done = mem_ready_i && (opcode == OpSwd);
                end
                StWb: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.wb_src    = (opcode == OpLwd) ? WbSrcMem : WbSrcAlu;
                    ctrl.reg_dst   = (opcode == OpAlu);
                    ctrl.lhi       = (opcode == OpLhi);
                    ctrl.inst_done = 1'b1;
                end
                StHalt:  ctrl.halted      = 1'b1;
                default: ctrl.mem_timeout = 1'b1;
            endcase
        end
    end

    assign mem_read_o    = ctrl.mem_read;
    assign mem_write_o   = ctrl.mem_write;
    assign i_or_d_o      = ctrl.i_or_d;
    assign ir_write_o    = ctrl.ir_write;
    assign pc_write_o    = ctrl.pc_write;
    assign pc_src_o      = ctrl.pc_src;
    assign reg_write_o   = ctrl.reg_write;
    assign reg_dst_o     = ctrl.reg_dst;
    assign alu_src_o     = ctrl.alu_src;
    assign alu_control_o = ALU_CTRL_W'(ctrl.alu_ctrl);
    assign wb_src_o      = ctrl.wb_src;
    assign lhi_o         = ctrl.lhi;
    assign inst_done_o   = ctrl.inst_done;
    assign mem_timeout_o = ctrl.mem_timeout;
    assign halted_o      = ctrl.halted;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: per-instruction expected strobe sequences built from the ISA rules.
module tb_multicycle_control_unit;
    import multicycle_control_unit_pkg::*;

    localparam int unsigned Timeout = 4;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] alu_src;
        logic [2:0] alu_control;
        logic [1:0] wb_src;
        logic       lhi;
        logic       inst_done;
        logic       mem_timeout;
        logic       halted;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] inst;
    logic        alu_zero, mem_ready;
    logic        mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write, reg_dst;
    logic        lhi, inst_done, mem_timeout, halted;
    logic [1:0]  pc_src, alu_src, wb_src;
    logic [2:0]  alu_control;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    logic rdy_q[$];

    always #5 clk = ~clk;

    multicycle_control_unit #(
        .WORD_SIZE   (16),
        .ALU_CTRL_W  (3),
        .MEM_TIMEOUT (Timeout)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .inst_i        (inst),
        .alu_zero_i    (alu_zero),
        .mem_ready_i   (mem_ready),
        .mem_read_o    (mem_read),
        .mem_write_o   (mem_write),
        .i_or_d_o      (i_or_d),
        .ir_write_o    (ir_write),
        .pc_write_o    (pc_write),
        .pc_src_o      (pc_src),
        .reg_write_o   (reg_write),
        .reg_dst_o     (reg_dst),
        .alu_src_o     (alu_src),
        .alu_control_o (alu_control),
        .wb_src_o      (wb_src),
        .lhi_o         (lhi),
        .inst_done_o   (inst_done),
        .mem_timeout_o (mem_timeout),
        .halted_o      (halted)
    );

    function automatic exp_t observed();
        exp_t a;
        a = '{mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src, reg_write, reg_dst,
              alu_src, alu_control, wb_src, lhi, inst_done, mem_timeout, halted};
        return a;
    endfunction

    task automatic push(input exp_t e, input logic r);
        exp_q.push_back(e);
        rdy_q.push_back(r);
    endtask

    // Plays the queued cycles; starts and ends just after a rising edge.
    task automatic play(input logic [15:0] ins, input logic az, input string name);
        exp_t act;
        for (int i = 0; i < exp_q.size(); i++) begin
            inst      = ins;
            alu_zero  = az;
            mem_ready = rdy_q[i];
            @(negedge clk);
            act = observed();
            n_checks++;
            if (act !== exp_q[i]) begin
                n_errors++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, i, act, exp_q[i]);
            end
            @(posedge clk);
            #1;
        end
        exp_q.delete();
        rdy_q.delete();
    endtask

    // Queue the expected cycles of one instruction, from fetch to retirement.
    task automatic build_inst(input logic [15:0] ins, input logic az, input int fw, input int mw);
        exp_t e;
        logic [3:0] op;
        logic taken;
        op = ins[15:12];
        for (int k = 0; k < fw; k++) begin
            e = '0; e.mem_read = 1'b1; push(e, 1'b0);
        end
        e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1; push(e, 1'b1);
        e = '0;
        case (op)
            OpJmp: begin e.pc_write = 1'b1; e.pc_src = 2'b01; e.inst_done = 1'b1; end
            OpHlt: begin e.halted = 1'b1; e.inst_done = 1'b1; end
            OpAlu, OpAdi, OpOri, OpLhi, OpLwd, OpSwd, OpBne, OpBeq, OpJal: ;
            default: e.inst_done = 1'b1;
        endcase
        push(e, 1'($urandom_range(0, 1)));
        if (e.inst_done) return;
        e = '0;
        case (op)
            OpAlu: e.alu_control = ins[2:0];
            OpAdi, OpLwd, OpSwd: e.alu_src = 2'b01;
            OpOri: begin e.alu_src = 2'b10; e.alu_control = 3'b011; end
            OpLhi: begin e.alu_src = 2'b10; e.alu_control = 3'b110; end
            OpBne, OpBeq: begin
                taken = (op == OpBne) ? !az : az;
                e.alu_control = 3'b001;
                e.inst_done = 1'b1;
                if (taken) begin e.pc_write = 1'b1; e.pc_src = 2'b10; end
            end
            default: begin
                e.reg_write = 1'b1; e.wb_src = 2'b10;
                e.pc_write = 1'b1; e.pc_src = 2'b01; e.inst_done = 1'b1;
            end
        endcase
        push(e, 1'($urandom_range(0, 1)));
        if (e.inst_done) return;
        if (op == OpLwd || op == OpSwd) begin
            for (int k = 0; k <= mw; k++) begin
                e = '0; e.i_or_d = 1'b1;
                e.mem_read = (op == OpLwd);
                e.mem_write = (op == OpSwd);
                e.inst_done = (k == mw) && (op == OpSwd);
                push(e, k == mw);
            end
            if (op == OpSwd) return;
        end
        e = '0; e.reg_write = 1'b1; e.inst_done = 1'b1;
        e.wb_src = (op == OpLwd) ? 2'b01 : 2'b00;
        e.reg_dst = (op == OpAlu);
        e.lhi = (op == OpLhi);
        push(e, 1'($urandom_range(0, 1)));
    endtask

    task automatic run_inst(input logic [15:0] ins, input logic az, input int fw, input int mw,
                            input string name);
        build_inst(ins, az, fw, mw);
        play(ins, az, name);
    endtask

    task automatic check_zero(input string name);
        exp_t act;
        act = observed();
        n_checks++;
        if (act !== exp_t'(0)) begin
            n_errors++;
            $display("FAIL %s: got %h expected 00000", name, act);
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        #1;
        check_zero("reset_asserted");
        @(negedge clk);
        check_zero("reset_held");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_zero("reset_release_gap");
        @(posedge clk);
        #1;
    endtask

    task automatic test_adi();
        run_inst({OpAdi, 2'd0, 2'd1, 8'd5}, 1'b0, 0, 0, "adi");
    endtask

    task automatic test_lwd_wait();
        run_inst({OpLwd, 2'd2, 2'd3, 8'h10}, 1'b0, 0, 3, "lwd_wait3");
    endtask

    task automatic test_branch();
        run_inst({OpBeq, 2'd1, 2'd2, 8'h04}, 1'b1, 0, 0, "beq_taken");
        run_inst({OpBeq, 2'd1, 2'd2, 8'h04}, 1'b0, 0, 0, "beq_not_taken");
        run_inst({OpBne, 2'd1, 2'd2, 8'h04}, 1'b0, 1, 0, "bne_taken");
        run_inst({OpBne, 2'd1, 2'd2, 8'h04}, 1'b1, 0, 0, "bne_not_taken");
    endtask

    task automatic test_jmp();
        run_inst({OpJmp, 12'h123}, 1'b0, 0, 0, "jmp");
        run_inst({OpJal, 12'h456}, 1'b0, 0, 0, "jal");
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [15];
        logic [15:0] ins;
        ops = '{OpAlu, OpAdi, OpOri, OpLhi, OpLwd, OpSwd, OpBne, OpBeq, OpJmp, OpJal,
                4'd2, 4'd3, 4'd12, 4'd13, 4'd14};
        for (int n = 0; n < 60; n++) begin
            ins = {ops[$urandom_range(0, 14)], 12'($urandom)};
            run_inst(ins, 1'($urandom_range(0, 1)), $urandom_range(0, Timeout - 1),
                     $urandom_range(0, Timeout - 1), "random");
        end
    endtask

    task automatic test_halt();
        exp_t e;
        build_inst({OpHlt, 12'h000}, 1'b0, 1, 0);
        e = '0; e.halted = 1'b1;
        for (int k = 0; k < 6; k++) push(e, 1'($urandom_range(0, 1)));
        play({OpHlt, 12'h000}, 1'b0, "halt");
        test_reset();
    endtask

    task automatic test_timeout();
        exp_t e;
        for (int k = 0; k < int'(Timeout); k++) begin
            e = '0; e.mem_read = 1'b1; push(e, 1'b0);
        end
        e = '0; e.mem_timeout = 1'b1;
        for (int k = 0; k < 6; k++) push(e, 1'($urandom_range(0, 1)));
        play({OpAdi, 12'h001}, 1'b0, "timeout");
        test_reset();
    endtask

    task automatic test_reset_mid_mem();
        exp_t e;
        logic [15:0] ins;
        ins = {OpSwd, 2'd1, 2'd2, 8'h20};
        build_inst(ins, 1'b0, 0, 3);
        // Keep IF..EX plus the first MEM stall; drop the rest.
        while (exp_q.size() > 4) begin
            e = exp_q.pop_back();
            void'(rdy_q.pop_back());
        end
        play(ins, 1'b0, "swd_pre_reset");
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (mem_write !== 1'b1) begin
            n_errors++;
            $display("FAIL swd_mem_stall: mem_write got %b expected 1", mem_write);
        end
        reset_n = 1'b0;
        #1;
        check_zero("swd_reset_drop");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_zero("swd_reset_gap");
        @(posedge clk);
        #1;
        run_inst({OpAdi, 2'd0, 2'd1, 8'd5}, 1'b0, 0, 0, "restart_adi");
    endtask

    initial begin
        reset_n   = 1'b0;
        inst      = 16'h0;
        alu_zero  = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_adi();
        test_lwd_wait();
        test_branch();
        test_jmp();
        test_back_to_back();
        test_halt();
        test_timeout();
        test_reset_mid_mem();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
